// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and helpers for the fetch unit: run-state encoding, PCreg select codes,
// and the conditional-jump decision.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALT
    } fetch_state_t;

    localparam logic [1:0] PCSEL_NONE = 2'b00;
    localparam logic [1:0] PCSEL_R1   = 2'b01;
    localparam logic [1:0] PCSEL_R2   = 2'b10;
    localparam logic [1:0] PCSEL_R3   = 2'b11;

    // je+jne together is an unconditional jump; a jump with no PCreg selected never fires.
    function automatic logic jump_taken(input logic je, input logic jne, input logic zf,
                                        input logic [1:0] sel);
        return (sel != PCSEL_NONE) && ((je && jne) || (je && zf) || (jne && !zf));
    endfunction

endpackage

// File: rtl/pc_fetch_unit_save_regs.sv
// pc_save_regs: the three saved-address registers PCreg1..3, one write port,
// one combinational read port; select 00 reads as zero and never writes.
module pc_save_regs
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [1:0]      wr_sel,
    input  logic [PC_W-1:0] wr_data,
    input  logic [1:0]      rd_sel,
    output logic [PC_W-1:0] rd_data
);

    logic [PC_W-1:0] pcreg1;
    logic [PC_W-1:0] pcreg2;
    logic [PC_W-1:0] pcreg3;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcreg1 <= '0;
            pcreg2 <= '0;
            pcreg3 <= '0;
        end else if (wr_en) begin
            case (wr_sel)
                PCSEL_R1: pcreg1 <= wr_data;
                PCSEL_R2: pcreg2 <= wr_data;
                PCSEL_R3: pcreg3 <= wr_data;
                default:  ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            PCSEL_R1: rd_data = pcreg1;
            PCSEL_R2: rd_data = pcreg2;
            PCSEL_R3: rd_data = pcreg3;
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-side program counter, saved-address registers and Start/Run/Halt sequencing.
// Define PC_JUMP_COUNT_EN to add the saturating taken-jump counter on JumpCount.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int OFS_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             OffsetEn,
    input  logic [1:0]       PCRegSelect,
    input  logic [OFS_W-1:0] OffsetIn,
    input  logic             ZeroFlag,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
`ifdef PC_JUMP_COUNT_EN
    output logic [15:0]      JumpCount,
`endif
    output fetch_state_t     dbg_state
);

    fetch_state_t    state;
    logic [PC_W-1:0] ofs_ext;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] save_data;
    logic [PC_W-1:0] jump_target;
    logic            is_jump;
    logic            taken;
    logic            run_active;
    logic            save_en;

    // Offset is two's complement; narrow PCs simply drop the upper offset bits.
    generate
        if (OFS_W >= PC_W) begin : g_ofs_trunc
            logic unused_ofs_hi;
            assign ofs_ext       = OffsetIn[PC_W-1:0];
            assign unused_ofs_hi = ^OffsetIn;
        end else begin : g_ofs_sext
            assign ofs_ext = {{(PC_W-OFS_W){OffsetIn[OFS_W-1]}}, OffsetIn};
        end
    endgenerate

    always_comb begin
        is_jump    = JumpEqual | JumpNotEqual;
        taken      = jump_taken(JumpEqual, JumpNotEqual, ZeroFlag, PCRegSelect);
        pc_inc     = ProgCtr + PC_W'(1);
        save_data  = OffsetEn ? (ProgCtr + ofs_ext) : ProgCtr;
        run_active = (state == FS_RUN) && !Start && !Ack;
        save_en    = run_active && !is_jump && (PCRegSelect != PCSEL_NONE);
    end

    pc_save_regs #(
        .PC_W (PC_W)
    ) u_save_regs (
        .clk     (Clk),
        .reset   (Reset),
        .wr_en   (save_en),
        .wr_sel  (PCRegSelect),
        .wr_data (save_data),
        .rd_sel  (PCRegSelect),
        .rd_data (jump_target)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= FS_IDLE;
            ProgCtr <= '0;
            Done    <= 1'b0;
        end else if (Start) begin
            state   <= FS_IDLE;
            ProgCtr <= '0;
            Done    <= 1'b0;
        end else begin
            case (state)
                FS_IDLE: begin
                    state   <= FS_RUN;
                    ProgCtr <= '0;
                    Done    <= 1'b0;
                end
                FS_RUN: begin
                    if (Ack) begin
                        state <= FS_HALT;
                        Done  <= 1'b1;
                    end else if (is_jump && taken) begin
                        ProgCtr <= jump_target;
                    end else begin
                        ProgCtr <= pc_inc;
                    end
                end
                FS_HALT: begin
                    Done <= 1'b1;
                end
                default: begin
                    state   <= FS_IDLE;
                    ProgCtr <= '0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

`ifdef PC_JUMP_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Reset || Start) begin
            JumpCount <= '0;
        end else if (run_active && is_jump && taken && (JumpCount != 16'hFFFF)) begin
            JumpCount <= JumpCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a 10-bit PC instance for the main sequences and
// a 4-bit PC instance for wrap-around; expected values are pushed per cycle and popped by a monitor.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset, Start, Start_s;
    logic       Ack, JumpEqual, JumpNotEqual, OffsetEn, ZeroFlag;
    logic [1:0] PCRegSelect;
    logic [7:0] OffsetIn;

    logic [9:0]   ProgCtr;
    logic         Done;
    fetch_state_t dbg_state;
    logic [3:0]   pc_s;
    logic         unused_done_s;
    fetch_state_t unused_state_s;
    logic [15:0]  jc_act;

    always #5 Clk = ~Clk;

    pc_fetch_unit u_dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Ack          (Ack),
        .JumpEqual    (JumpEqual),
        .JumpNotEqual (JumpNotEqual),
        .OffsetEn     (OffsetEn),
        .PCRegSelect  (PCRegSelect),
        .OffsetIn     (OffsetIn),
        .ZeroFlag     (ZeroFlag),
        .ProgCtr      (ProgCtr),
        .Done         (Done),
`ifdef PC_JUMP_COUNT_EN
        .JumpCount    (jc_act),
`endif
        .dbg_state    (dbg_state)
    );

`ifdef PC_JUMP_COUNT_EN
    logic [15:0] unused_jc_s;
`else
    assign jc_act = 16'h0000;
`endif

    pc_fetch_unit #(
        .PC_W  (4),
        .OFS_W (8)
    ) u_dut_small (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start_s),
        .Ack          (1'b0),
        .JumpEqual    (1'b0),
        .JumpNotEqual (1'b0),
        .OffsetEn     (1'b0),
        .PCRegSelect  (2'b00),
        .OffsetIn     (8'h00),
        .ZeroFlag     (1'b0),
        .ProgCtr      (pc_s),
        .Done         (unused_done_s),
`ifdef PC_JUMP_COUNT_EN
        .JumpCount    (unused_jc_s),
`endif
        .dbg_state    (unused_state_s)
    );

    // Expected observation: {JumpCount, state, Done, ProgCtr, small ProgCtr}
    logic [32:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [15:0] e_jc;
    logic [1:0]  e_state;
    logic        e_done;
    logic [9:0]  e_pc;
    logic [3:0]  e_spc;

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [32:0] exp_v;
            logic [32:0] act_v;
            string       nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {jc_act, dbg_state, Done, ProgCtr, pc_s};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL %s: got jc=%h st=%0d done=%b pc=%0d spc=%0d, expected jc=%h st=%0d done=%b pc=%0d spc=%0d",
                          nm, act_v[32:17], act_v[16:15], act_v[14], act_v[13:4], act_v[3:0],
                          exp_v[32:17], exp_v[16:15], exp_v[14], exp_v[13:4], exp_v[3:0]);
        end
    end

    task automatic cyc(input string nm);
        @(posedge Clk);
        #1;
        exp_q.push_back({e_jc, e_state, e_done, e_pc, e_spc});
        name_q.push_back(nm);
    endtask

    task automatic drive(input logic je, input logic jne, input logic [1:0] sel,
                         input logic oen, input logic [7:0] ofs, input logic zf,
                         input logic ack);
        JumpEqual    = je;
        JumpNotEqual = jne;
        PCRegSelect  = sel;
        OffsetEn     = oen;
        OffsetIn     = ofs;
        ZeroFlag     = zf;
        Ack          = ack;
    endtask

    task automatic bump_jc();
`ifdef PC_JUMP_COUNT_EN
        e_jc = e_jc + 16'd1;
`endif
    endtask

    task automatic plain_to(input logic [9:0] tgt);
        drive(0, 0, 2'b00, 0, 8'h00, 0, 0);
        while (e_pc != tgt) begin
            e_pc = e_pc + 10'd1;
            cyc("plain");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Start = 1'b1; Start_s = 1'b1;
        drive(0, 0, 2'b00, 0, 8'h00, 0, 0);
        e_jc = '0; e_state = FS_IDLE; e_done = 1'b0; e_pc = '0; e_spc = '0;
        cyc("reset");
        cyc("reset_hold");
        Reset = 1'b0;
        cyc("idle_start_high");
        Start = 1'b0; e_state = FS_RUN;
        cyc("start_to_run_pc0");
        plain_to(10'd7);

        drive(0, 0, 2'b10, 0, 8'h00, 0, 0); e_pc = 10'd8;
        cyc("spc_r2_at_7");
        plain_to(10'd20);
        drive(1, 0, 2'b10, 0, 8'h00, 1, 0); e_pc = 10'd7; bump_jc();
        cyc("je_taken_r2");
        plain_to(10'd20);
        drive(0, 1, 2'b01, 0, 8'h00, 1, 0); e_pc = 10'd21;
        cyc("jne_not_taken");
        drive(1, 0, 2'b00, 0, 8'h00, 1, 0); e_pc = 10'd22;
        cyc("je_sel_none");
        plain_to(10'd100);
        drive(0, 0, 2'b11, 1, 8'hF6, 0, 0); e_pc = 10'd101;
        cyc("spc_r3_ofs_minus10");
        plain_to(10'd105);
        drive(0, 1, 2'b11, 0, 8'h00, 0, 0); e_pc = 10'd90; bump_jc();
        cyc("jne_taken_r3_90");
        drive(1, 1, 2'b10, 0, 8'h00, 0, 0); e_pc = 10'd7; bump_jc();
        cyc("je_jne_both_taken");
        drive(0, 0, 2'b01, 1, 8'h05, 0, 0); e_pc = 10'd8;
        cyc("spc_r1_ofs_plus5");
        drive(1, 0, 2'b01, 0, 8'h00, 1, 0); e_pc = 10'd12; bump_jc();
        cyc("save_then_jump_r1");
        drive(0, 0, 2'b10, 1, 8'hF0, 0, 0); e_pc = 10'd13;
        cyc("spc_r2_ofs_wrap");
        drive(1, 0, 2'b10, 0, 8'h00, 1, 0); e_pc = 10'd1020; bump_jc();
        cyc("je_to_1020");
        plain_to(10'd42);

        drive(1, 0, 2'b01, 0, 8'h00, 1, 1); e_state = FS_HALT; e_done = 1'b1;
        cyc("ack_halt_at_42");
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 2'b11, 1, 8'h33, i[0], i[1]);
            cyc("halt_frozen");
        end
        drive(0, 0, 2'b00, 0, 8'h00, 0, 0);
        Start = 1'b1; e_state = FS_IDLE; e_done = 1'b0; e_pc = '0; e_jc = '0;
        cyc("start_clears_halt");

        Start = 1'b0; e_state = FS_RUN;
        cyc("rerun_pc0");
        plain_to(10'd3);
        drive(0, 0, 2'b01, 0, 8'h00, 0, 0); e_pc = 10'd4;
        cyc("spc_r1_before_reset");
        drive(1, 0, 2'b01, 0, 8'h00, 1, 0);
        Reset = 1'b1; e_pc = '0; e_state = FS_IDLE; e_jc = '0;
        cyc("reset_during_jump");
        Reset = 1'b0; drive(0, 0, 2'b00, 0, 8'h00, 0, 0); e_state = FS_RUN;
        cyc("run_after_reset");
        e_pc = 10'd1;
        cyc("plain_after_reset");
        drive(1, 0, 2'b01, 0, 8'h00, 1, 0); e_pc = 10'd0; bump_jc();
        cyc("pcreg1_cleared_by_reset");

        drive(0, 0, 2'b00, 0, 8'h00, 0, 0);
        Start = 1'b1; e_state = FS_IDLE; e_pc = '0; e_jc = '0;
        Start_s = 1'b0;
        cyc("small_start_pc0");
        for (int i = 0; i < 16; i++) begin
            e_spc = e_spc + 4'd1;
            cyc("small_pc_wrap");
        end

        repeat (4) @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
